// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit -- EX-stage control unit for the MIPS-subset pipeline.
//
// Decodes instruction_EX combinationally into ALU, register-file, HI/LO, data
// memory and GPIO controls. Two pieces of sequential state sit on top of the
// decode:
//   * a flush FSM that squashes the BRANCH_PENALTY instructions following a
//     taken branch/jump;
//   * a multiplier busy tracker that holds HI/LO consumers (mfhi, mflo, mult,
//     multu) in EX until the previous mult result is valid.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst            synchronous reset, active-low; forces every output to 0
//   instruction_EX instruction currently in EX
//   zero_EX        ALU zero flag for the EX instruction (branch condition)
//   alu_op         ALU operation
//   shamt_EX       shift amount
//   enhilo_EX      HI/LO write enable
//   regsel_EX      writeback source: 0 ALU, 1 HI, 2 LO, 3 GPIO-in
//   regwrite_EX    register write enable
//   rdrt_EX        destination select, 1 = rt, 0 = rd
//   memwrite_EX    data memory write
//   alu_src_EX     ALU B source: 0 rt, 1 sign-ext imm, 2 zero-ext imm
//   pc_src_EX      next PC: 0 PC+4, 1 branch target, 2 jump target
//   gpio_out_we    one-hot GPIO output strobe
//   gpio_in_sel    one-hot GPIO input select
//   stall_FETCH    hold PC and the fetch/EX register
//   illegal_EX     unrecognised instruction in EX
module pipe_ctrl_unit #(
  parameter int MULT_LATENCY   = 4,
  parameter int BRANCH_PENALTY = 1,
  parameter int GPIO_CH        = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        instruction_EX,
  input  logic               zero_EX,
  output logic [3:0]         alu_op,
  output logic [4:0]         shamt_EX,
  output logic               enhilo_EX,
  output logic [1:0]         regsel_EX,
  output logic               regwrite_EX,
  output logic               rdrt_EX,
  output logic               memwrite_EX,
  output logic [1:0]         alu_src_EX,
  output logic [1:0]         pc_src_EX,
  output logic [GPIO_CH-1:0] gpio_out_we,
  output logic [GPIO_CH-1:0] gpio_in_sel,
  output logic               stall_FETCH,
  output logic               illegal_EX
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t     state_reg;
  logic [1:0] fcnt_reg;
  logic [3:0] mcnt_reg;

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] shamt;
  logic [2:0] ch;
  logic       ch_ok;
  logic [7:0] ch_onehot;

  assign op    = instruction_EX[31:26];
  assign funct = instruction_EX[5:0];
  assign shamt = instruction_EX[10:6];
  assign ch    = instruction_EX[23:21];   // rs mod 8
  assign ch_ok = ({1'b0, ch} < 4'(GPIO_CH));

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_ch
      assign ch_onehot[gi] = (ch == 3'(gi));
    end
  endgenerate

  // Raw decode, before squash/stall gating.
  logic [3:0] d_alu_op;
  logic [4:0] d_shamt;
  logic       d_enhilo;
  logic [1:0] d_regsel;
  logic       d_regwrite;
  logic       d_rdrt;
  logic       d_memwrite;
  logic [1:0] d_alu_src;
  logic [1:0] d_pc_src;
  logic [7:0] d_gpio_out;
  logic [7:0] d_gpio_in;
  logic       d_illegal;
  logic       d_hilo_use;   // instruction must wait for the multiplier
  logic       d_mult;
  logic       d_taken;

  always_comb begin
    d_alu_op   = 4'b0000;
    d_shamt    = 5'd0;
    d_enhilo   = 1'b0;
    d_regsel   = 2'd0;
    d_regwrite = 1'b0;
    d_rdrt     = 1'b0;
    d_memwrite = 1'b0;
    d_alu_src  = 2'd0;
    d_pc_src   = 2'd0;
    d_gpio_out = 8'd0;
    d_gpio_in  = 8'd0;
    d_illegal  = 1'b0;
    d_hilo_use = 1'b0;
    d_mult     = 1'b0;
    d_taken    = 1'b0;
    case (op)
      6'b000000: begin
        case (funct)
          6'b100000, 6'b100001: begin d_alu_op = 4'b0100; d_regwrite = 1'b1; end
          6'b100010, 6'b100011: begin d_alu_op = 4'b0101; d_regwrite = 1'b1; end
          6'b100100: begin d_alu_op = 4'b0000; d_regwrite = 1'b1; end
          6'b100101: begin d_alu_op = 4'b0001; d_regwrite = 1'b1; end
          6'b100111: begin d_alu_op = 4'b0010; d_regwrite = 1'b1; end
          6'b100110: begin d_alu_op = 4'b0011; d_regwrite = 1'b1; end
          6'b101010: begin d_alu_op = 4'b1100; d_regwrite = 1'b1; end
          6'b101011: begin d_alu_op = 4'b1101; d_regwrite = 1'b1; end
          6'b000000: begin
            // The all-zero word is the canonical NOP and drives nothing.
            if (instruction_EX != 32'd0) begin
              d_alu_op   = 4'b1000;
              d_shamt    = shamt;
              d_regwrite = 1'b1;
            end
          end
          6'b000010: begin
            if (shamt != 5'd0) begin
              d_alu_op = 4'b1001; d_shamt = shamt; d_regwrite = 1'b1;
            end else if (ch_ok) begin
              d_gpio_out = ch_onehot;              // srl with shamt 0 = GPIO write
            end else begin
              d_illegal = 1'b1;
            end
          end
          6'b000011: begin
            if (shamt != 5'd0) begin
              d_alu_op = 4'b1010; d_shamt = shamt; d_regwrite = 1'b1;
            end else if (ch_ok) begin
              d_gpio_in = ch_onehot;               // sra with shamt 0 = GPIO read
              d_regsel = 2'd3; d_regwrite = 1'b1;
            end else begin
              d_illegal = 1'b1;
            end
          end
          6'b011000: begin d_alu_op = 4'b0110; d_enhilo = 1'b1; d_hilo_use = 1'b1; d_mult = 1'b1; end
          6'b011001: begin d_alu_op = 4'b0111; d_enhilo = 1'b1; d_hilo_use = 1'b1; d_mult = 1'b1; end
          6'b010000: begin d_regsel = 2'd1; d_regwrite = 1'b1; d_hilo_use = 1'b1; end
          6'b010010: begin d_regsel = 2'd2; d_regwrite = 1'b1; d_hilo_use = 1'b1; end
          default:   d_illegal = 1'b1;
        endcase
      end
      6'b001000, 6'b001001: begin d_alu_op = 4'b0100; d_alu_src = 2'd1; d_rdrt = 1'b1; d_regwrite = 1'b1; end
      6'b001100: begin d_alu_op = 4'b0000; d_alu_src = 2'd2; d_rdrt = 1'b1; d_regwrite = 1'b1; end
      6'b001101: begin d_alu_op = 4'b0001; d_alu_src = 2'd2; d_rdrt = 1'b1; d_regwrite = 1'b1; end
      6'b001110: begin d_alu_op = 4'b0011; d_alu_src = 2'd2; d_rdrt = 1'b1; d_regwrite = 1'b1; end
      6'b001010: begin d_alu_op = 4'b1100; d_alu_src = 2'd1; d_rdrt = 1'b1; d_regwrite = 1'b1; end
      6'b001111: begin
        d_alu_op = 4'b1000; d_shamt = 5'd16; d_alu_src = 2'd2; d_rdrt = 1'b1; d_regwrite = 1'b1;
      end
      6'b101011: begin d_alu_op = 4'b0100; d_alu_src = 2'd1; d_memwrite = 1'b1; end
      6'b000100: begin d_alu_op = 4'b0101; d_taken = zero_EX;  d_pc_src = zero_EX  ? 2'd1 : 2'd0; end
      6'b000101: begin d_alu_op = 4'b0101; d_taken = ~zero_EX; d_pc_src = ~zero_EX ? 2'd1 : 2'd0; end
      6'b000010: begin d_taken = 1'b1; d_pc_src = 2'd2; end
      default:   d_illegal = 1'b1;
    endcase
  end

  logic flushing;
  logic busy;
  logic stall;
  logic squash;
  logic taken;
  logic mult_issue;

  assign flushing   = (state_reg == FLUSH);
  assign busy       = (mcnt_reg != 4'd0);
  // A squashed instruction never executes, so it has no reason to wait for
  // HI/LO; holding it would let it escape the flush window unsquashed.
  assign stall      = busy & d_hilo_use & ~flushing;
  assign squash     = flushing | stall;
  assign taken      = d_taken & ~flushing;
  assign mult_issue = d_mult & ~flushing & ~stall;

  always_comb begin
    alu_op      = 4'b0000;
    shamt_EX    = 5'd0;
    enhilo_EX   = 1'b0;
    regsel_EX   = 2'd0;
    regwrite_EX = 1'b0;
    rdrt_EX     = 1'b0;
    memwrite_EX = 1'b0;
    alu_src_EX  = 2'd0;
    pc_src_EX   = 2'd0;
    gpio_out_we = '0;
    gpio_in_sel = '0;
    stall_FETCH = 1'b0;
    illegal_EX  = 1'b0;
    if (rst) begin
      alu_op      = d_alu_op;
      shamt_EX    = d_shamt;
      regsel_EX   = d_regsel;
      rdrt_EX     = d_rdrt;
      alu_src_EX  = d_alu_src;
      gpio_in_sel = d_gpio_in[GPIO_CH-1:0];
      enhilo_EX   = d_enhilo   & ~squash;
      regwrite_EX = d_regwrite & ~squash;
      memwrite_EX = d_memwrite & ~squash;
      gpio_out_we = squash ? '0 : d_gpio_out[GPIO_CH-1:0];
      pc_src_EX   = flushing ? 2'd0 : d_pc_src;
      stall_FETCH = stall;
      illegal_EX  = d_illegal & ~flushing;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= RUN;
      fcnt_reg  <= 2'd0;
      mcnt_reg  <= 4'd0;
    end else begin
      case (state_reg)
        RUN: begin
          if (taken) begin
            state_reg <= FLUSH;
            fcnt_reg  <= 2'(BRANCH_PENALTY - 1);
          end
        end
        FLUSH: begin
          if (fcnt_reg == 2'd0) state_reg <= RUN;
          else                  fcnt_reg  <= fcnt_reg - 2'd1;
        end
        default: state_reg <= RUN;
      endcase
      // mult_issue implies the tracker is idle (otherwise it would stall).
      if (mult_issue)           mcnt_reg <= 4'(MULT_LATENCY - 1);
      else if (mcnt_reg != 4'd0) mcnt_reg <= mcnt_reg - 4'd1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Testbench for pipe_ctrl_unit: directed sequences followed by random
// instructions. The driver feeds each cycle's instruction to a reference model
// that pushes the expected outputs into a queue; a monitor pops and compares
// at every falling edge.
module tb_pipe_ctrl_unit;

  localparam int ML  = 4;
  localparam int BP  = 2;
  localparam int GCH = 2;
  localparam int W   = 21 + 2 * GCH;

  logic           clk = 1'b0;
  logic           rst;
  logic [31:0]    instruction_EX;
  logic           zero_EX;
  logic [3:0]     alu_op;
  logic [4:0]     shamt_EX;
  logic           enhilo_EX;
  logic [1:0]     regsel_EX;
  logic           regwrite_EX;
  logic           rdrt_EX;
  logic           memwrite_EX;
  logic [1:0]     alu_src_EX;
  logic [1:0]     pc_src_EX;
  logic [GCH-1:0] gpio_out_we;
  logic [GCH-1:0] gpio_in_sel;
  logic           stall_FETCH;
  logic           illegal_EX;

  pipe_ctrl_unit #(.MULT_LATENCY(ML), .BRANCH_PENALTY(BP), .GPIO_CH(GCH)) dut (
    .clk(clk), .rst(rst), .instruction_EX(instruction_EX), .zero_EX(zero_EX),
    .alu_op(alu_op), .shamt_EX(shamt_EX), .enhilo_EX(enhilo_EX), .regsel_EX(regsel_EX),
    .regwrite_EX(regwrite_EX), .rdrt_EX(rdrt_EX), .memwrite_EX(memwrite_EX),
    .alu_src_EX(alu_src_EX), .pc_src_EX(pc_src_EX), .gpio_out_we(gpio_out_we),
    .gpio_in_sel(gpio_in_sel), .stall_FETCH(stall_FETCH), .illegal_EX(illegal_EX)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [31:0]   ins;
    logic [W-1:0]  v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state, in absolute cycle numbers: instructions in cycles
  // up to squash_until are squashed; HI/LO is valid from ready_cyc onwards.
  int mcyc         = 0;
  int squash_until = -1;
  int ready_cyc    = 0;

  typedef enum {I_NOP, I_ADD, I_SUB, I_AND, I_OR, I_NOR, I_XOR, I_SLT, I_SLTU,
                I_SLL, I_SRL, I_SRA, I_GOUT, I_GIN, I_MULT, I_MULTU, I_MFHI, I_MFLO,
                I_ADDI, I_ANDI, I_ORI, I_XORI, I_SLTI, I_LUI, I_SW, I_BEQ, I_BNE,
                I_J, I_BAD} mn_t;

  task automatic model_step(input logic [31:0] ins, input logic z, input logic r,
                            output logic [W-1:0] v, output bit hold);
    logic [5:0] op, fn;
    logic [4:0] sa;
    int         ch;
    mn_t        m;
    logic [3:0] a;    logic [4:0] sh;  logic eh;  logic [1:0] rsel;
    logic       rw;   logic rdrt;      logic mw;  logic [1:0] src;
    logic [1:0] pc;   logic [7:0] go;  logic [7:0] gin;
    logic       ill;  bit taken;       bit in_flush; bit busy; bit stall;
    op = ins[31:26]; fn = ins[5:0]; sa = ins[10:6]; ch = int'(ins[25:21]) % 8;
    hold = 1'b0;
    v = '0;
    if (!r) begin
      squash_until = -1;
      ready_cyc    = 0;
      mcyc++;
      return;
    end
    m = I_BAD;
    if (ins == 32'd0) m = I_NOP;
    else if (op == 6'd0) begin
      case (fn)
        6'h20, 6'h21: m = I_ADD;
        6'h22, 6'h23: m = I_SUB;
        6'h24: m = I_AND;   6'h25: m = I_OR;    6'h27: m = I_NOR;   6'h26: m = I_XOR;
        6'h2a: m = I_SLT;   6'h2b: m = I_SLTU;  6'h00: m = I_SLL;
        6'h02: m = (sa != 0) ? I_SRL : I_GOUT;
        6'h03: m = (sa != 0) ? I_SRA : I_GIN;
        6'h18: m = I_MULT;  6'h19: m = I_MULTU; 6'h10: m = I_MFHI;  6'h12: m = I_MFLO;
        default: m = I_BAD;
      endcase
    end else begin
      case (op)
        6'h08, 6'h09: m = I_ADDI;
        6'h0c: m = I_ANDI;  6'h0d: m = I_ORI;   6'h0e: m = I_XORI;  6'h0a: m = I_SLTI;
        6'h0f: m = I_LUI;   6'h2b: m = I_SW;    6'h04: m = I_BEQ;   6'h05: m = I_BNE;
        6'h02: m = I_J;
        default: m = I_BAD;
      endcase
    end
    if ((m == I_GOUT || m == I_GIN) && ch >= GCH) m = I_BAD;

    a = 0; sh = 0; eh = 0; rsel = 0; rw = 0; rdrt = 0; mw = 0; src = 0; pc = 0;
    go = 0; gin = 0; ill = 0;
    case (m)
      I_ADD:  begin a = 4'b0100; rw = 1; end
      I_SUB:  begin a = 4'b0101; rw = 1; end
      I_AND:  begin a = 4'b0000; rw = 1; end
      I_OR:   begin a = 4'b0001; rw = 1; end
      I_NOR:  begin a = 4'b0010; rw = 1; end
      I_XOR:  begin a = 4'b0011; rw = 1; end
      I_SLT:  begin a = 4'b1100; rw = 1; end
      I_SLTU: begin a = 4'b1101; rw = 1; end
      I_SLL:  begin a = 4'b1000; sh = sa; rw = 1; end
      I_SRL:  begin a = 4'b1001; sh = sa; rw = 1; end
      I_SRA:  begin a = 4'b1010; sh = sa; rw = 1; end
      I_GOUT: go = 8'(1 << ch);
      I_GIN:  begin gin = 8'(1 << ch); rsel = 3; rw = 1; end
      I_MULT: begin a = 4'b0110; eh = 1; end
      I_MULTU:begin a = 4'b0111; eh = 1; end
      I_MFHI: begin rsel = 1; rw = 1; end
      I_MFLO: begin rsel = 2; rw = 1; end
      I_ADDI: begin a = 4'b0100; src = 1; rdrt = 1; rw = 1; end
      I_ANDI: begin a = 4'b0000; src = 2; rdrt = 1; rw = 1; end
      I_ORI:  begin a = 4'b0001; src = 2; rdrt = 1; rw = 1; end
      I_XORI: begin a = 4'b0011; src = 2; rdrt = 1; rw = 1; end
      I_SLTI: begin a = 4'b1100; src = 1; rdrt = 1; rw = 1; end
      I_LUI:  begin a = 4'b1000; sh = 16; src = 2; rdrt = 1; rw = 1; end
      I_SW:   begin a = 4'b0100; src = 1; mw = 1; end
      I_BEQ, I_BNE: a = 4'b0101;
      I_BAD:  ill = 1;
      default: ;
    endcase
    taken = (m == I_BEQ && z) || (m == I_BNE && !z) || (m == I_J);
    pc = (m == I_J) ? 2'd2 : (taken ? 2'd1 : 2'd0);

    in_flush = (mcyc <= squash_until);
    busy     = (mcyc < ready_cyc);
    stall    = busy && !in_flush &&
               (m == I_MULT || m == I_MULTU || m == I_MFHI || m == I_MFLO);
    if (in_flush || stall) begin rw = 0; mw = 0; eh = 0; go = 0; end
    if (in_flush) begin pc = 0; ill = 0; end

    if (!in_flush && taken) squash_until = mcyc + BP;
    if ((m == I_MULT || m == I_MULTU) && !in_flush && !stall) ready_cyc = mcyc + ML;
    hold = stall;
    v = {a, sh, eh, rsel, rw, rdrt, mw, src, pc, go[GCH-1:0], gin[GCH-1:0], stall, ill};
    mcyc++;
  endtask

  task automatic step(input logic [31:0] ins, input logic z, input logic r, output bit hold);
    exp_t e;
    instruction_EX = ins;
    zero_EX        = z;
    rst            = r;
    e.cyc = mcyc;
    e.ins = ins;
    model_step(ins, z, r, e.v, hold);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Fetch behaviour: a stalled instruction is presented again until it goes.
  task automatic issue(input logic [31:0] ins, input logic z);
    bit h;
    int n = 0;
    do begin
      step(ins, z, 1'b1, h);
      n++;
    end while (h && n < 20);
  endtask

  localparam logic [5:0] RFN [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27,
      6'h26, 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h18, 6'h19, 6'h10, 6'h12};
  localparam logic [5:0] IOP [11] = '{6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e, 6'h0a, 6'h0f,
      6'h2b, 6'h04, 6'h05, 6'h02};

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 9);
    if (k < 5) begin
      w[31:26] = 6'd0;
      w[5:0]   = RFN[$urandom_range(0, 16)];
      if ((w[5:0] == 6'h02 || w[5:0] == 6'h03) && $urandom_range(0, 1) == 1) w[10:6] = 5'd0;
    end else if (k < 9) begin
      w[31:26] = IOP[$urandom_range(0, 10)];
    end
    return w;
  endfunction

  // Monitor: one comparison per cycle, in the middle of the cycle.
  initial begin
    exp_t e;
    logic [W-1:0] got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {alu_op, shamt_EX, enhilo_EX, regsel_EX, regwrite_EX, rdrt_EX, memwrite_EX,
               alu_src_EX, pc_src_EX, gpio_out_we, gpio_in_sel, stall_FETCH, illegal_EX};
        checks++;
        if (got !== e.v) begin
          errors++;
          $display("FAIL outputs cyc=%0d instr=%h rst=%0b got=%h want=%h",
                   e.cyc, e.ins, rst, got, e.v);
        end else begin
          $display("ok   cyc=%0d instr=%h rst=%0b out=%h", e.cyc, e.ins, rst, got);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit h;
    rst = 1'b0;
    instruction_EX = 32'd0;
    zero_EX = 1'b0;
    @(posedge clk);
    #1;
    // Reset: outputs forced to zero whatever is in EX.
    step(32'h00221820, 1'b0, 1'b0, h);
    step(32'h08000010, 1'b0, 1'b0, h);
    step(32'h00220018, 1'b1, 1'b0, h);
    // add
    issue(32'h00221820, 1'b0);
    issue(32'h00000000, 1'b0);                // NOP
    // bne taken, two squashed addi, third addi executes
    issue(32'h14220003, 1'b0);
    issue(32'h20010005, 1'b0);
    issue(32'h20010005, 1'b0);
    issue(32'h20010005, 1'b0);
    // beq not taken, beq taken followed by a branch/illegal inside the window
    issue(32'h10220003, 1'b0);
    issue(32'h10220003, 1'b1);
    issue(32'h08000040, 1'b0);
    issue(32'hFC000000, 1'b0);
    issue(32'h00221820, 1'b0);
    // mult then mfhi: held until HI/LO valid
    issue(32'h00220018, 1'b0);
    issue(32'h00001810, 1'b0);
    // GPIO with two channels
    issue(32'h00200002, 1'b0);
    issue(32'h00600002, 1'b0);
    issue(32'h00001803, 1'b0);
    issue(32'h00E01803, 1'b0);
    // lui, sw, multu
    issue(32'h3C01ABCD, 1'b0);
    issue(32'hAC220004, 1'b0);
    issue(32'h00220019, 1'b0);
    issue(32'h00001812, 1'b0);
    // busy multiplier with a jump, aborted by reset
    issue(32'h00220018, 1'b0);
    issue(32'h00221820, 1'b0);
    issue(32'h08000010, 1'b0);
    step(32'h00001810, 1'b0, 1'b0, h);
    issue(32'h00001810, 1'b0);
    issue(32'h00221820, 1'b0);
    // Random traffic with occasional reset pulses
    for (int i = 0; i < 400; i++) begin
      logic [31:0] w;
      logic z;
      logic r;
      w = gen_instr();
      z = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 40) != 0);
      if (r) issue(w, z);
      else   step(w, z, 1'b0, h);
    end
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
